// File: rtl/gate_tt_sequencer.sv
// Truth-table self-test sequencer for a 2-input single-bit gate.
// It drives the four {a,b} vectors in turn and holds each one for HOLD_CYCLES.
// It then samples the gate output and compares it with a truth table latched at start.
// The results are the mismatch count, the first failing vector and a pass flag.
//
// state  | meaning
// IDLE   | waiting for start, gate inputs parked at 0
// APPLY  | driving vector idx, hold counter running
// CHECK  | one cycle: sample gate_y against truth_q[idx]
// FINISH | one cycle: done pulse, pass valid, inputs back to 0
module gate_tt_sequencer #(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] truth,
   output logic       gate_a,
   output logic       gate_b,
   input  logic       gate_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_cnt,
   output logic       fail_valid,
   output logic [1:0] first_fail
);

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_FINISH} state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   state_t           state, state_nxt;
   logic [1:0]       idx, idx_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [3:0]       truth_q, truth_q_nxt;
   logic             gate_a_nxt, gate_b_nxt, busy_nxt, done_nxt, pass_nxt;
   logic [2:0]       err_cnt_nxt;
   logic             fail_valid_nxt;
   logic [1:0]       first_fail_nxt;
   logic             mism;
   logic [2:0]       err_sum;

   // State and output registers; every output comes straight from a flop
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         idx        <= '0;
         cnt        <= '0;
         truth_q    <= '0;
         gate_a     <= 1'b0;
         gate_b     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= '0;
         fail_valid <= 1'b0;
         first_fail <= '0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         cnt        <= cnt_nxt;
         truth_q    <= truth_q_nxt;
         gate_a     <= gate_a_nxt;
         gate_b     <= gate_b_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         pass       <= pass_nxt;
         err_cnt    <= err_cnt_nxt;
         fail_valid <= fail_valid_nxt;
         first_fail <= first_fail_nxt;
      end
   end

   // Next-state and next-output decode; X/Z on gate_y counts as a mismatch
   always_comb begin
      state_nxt      = state;
      idx_nxt        = idx;
      cnt_nxt        = cnt;
      truth_q_nxt    = truth_q;
      gate_a_nxt     = gate_a;
      gate_b_nxt     = gate_b;
      busy_nxt       = busy;
      done_nxt       = 1'b0;
      pass_nxt       = pass;
      err_cnt_nxt    = err_cnt;
      fail_valid_nxt = fail_valid;
      first_fail_nxt = first_fail;
      mism           = (gate_y !== truth_q[idx]);
      err_sum        = err_cnt + {2'b00, mism};

      case (state)
         S_IDLE: begin
            gate_a_nxt = 1'b0;
            gate_b_nxt = 1'b0;
            busy_nxt   = 1'b0;
            if (start) begin
               truth_q_nxt    = truth;
               idx_nxt        = '0;
               cnt_nxt        = '0;
               err_cnt_nxt    = '0;
               fail_valid_nxt = 1'b0;
               first_fail_nxt = '0;
               pass_nxt       = 1'b0;
               busy_nxt       = 1'b1;
               state_nxt      = S_APPLY;
            end
         end
         S_APPLY: begin
            if (cnt == HOLD_LAST) begin
               cnt_nxt   = '0;
               state_nxt = S_CHECK;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_CHECK: begin
            err_cnt_nxt = err_sum;
            if (mism && !fail_valid) begin
               fail_valid_nxt = 1'b1;
               first_fail_nxt = idx;
            end
            if (idx == 2'd3) begin
               gate_a_nxt = 1'b0;
               gate_b_nxt = 1'b0;
               busy_nxt   = 1'b0;
               done_nxt   = 1'b1;
               pass_nxt   = (err_sum == 3'd0);
               state_nxt  = S_FINISH;
            end else begin
               idx_nxt                  = idx + 2'd1;
               {gate_a_nxt, gate_b_nxt} = idx + 2'd1;
               state_nxt                = S_APPLY;
            end
         end
         S_FINISH: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Bench for gate_tt_sequencer: the gate under test is a behavioural lookup table.
// Each run is checked cycle by cycle against a model of the vector schedule and the result counters.
module tb_gate_tt_sequencer;

   localparam int H   = 4;
   localparam int VEC = H + 1;
   localparam int RUN = 4 * VEC;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [3:0] truth;
   logic       gate_a, gate_b, gate_y;
   logic       busy, done, pass, fail_valid;
   logic [2:0] err_cnt;
   logic [1:0] first_fail;
   logic [3:0] gate_fn;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign gate_y = gate_fn[{gate_a, gate_b}];

   gate_tt_sequencer #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .truth(truth),
      .gate_a(gate_a), .gate_b(gate_b), .gate_y(gate_y),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .fail_valid(fail_valid), .first_fail(first_fail)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Number of mismatching vectors among the first n vectors.
   function automatic int n_mism(input logic [3:0] tt, input logic [3:0] fn, input int n);
      int c = 0;
      for (int v = 0; v < n; v++) if (tt[v] != fn[v]) c++;
      return c;
   endfunction

   // Lowest mismatching vector among the first n, or -1 if there is none.
   function automatic int first_mism(input logic [3:0] tt, input logic [3:0] fn, input int n);
      for (int v = 0; v < n; v++) if (tt[v] != fn[v]) return v;
      return -1;
   endfunction

   task automatic check_reset_vals(input string tag);
      chk({tag, " ab"},   {6'd0, gate_a, gate_b}, 8'd0);
      chk({tag, " busy"}, {7'd0, busy}, 8'd0);
      chk({tag, " done"}, {7'd0, done}, 8'd0);
      chk({tag, " pass"}, {7'd0, pass}, 8'd0);
      chk({tag, " err"},  {5'd0, err_cnt}, 8'd0);
      chk({tag, " fv"},   {7'd0, fail_valid}, 8'd0);
      chk({tag, " ff"},   {6'd0, first_fail}, 8'd0);
   endtask

   // Entered at the falling edge just after the accepting edge (cycle k=0); leaves at cycle k=RUN+1.
   // disturb=1 re-pulses start and zeroes truth while the run is busy.
   task automatic run_check(input string tag, input logic [3:0] tt, input logic [3:0] fn,
                            input int disturb);
      int done_k, fm, ne;
      for (int k = 0; k <= RUN + 1; k++) begin
         done_k = (k / VEC > 4) ? 4 : k / VEC;
         ne     = n_mism(tt, fn, done_k);
         fm     = first_mism(tt, fn, done_k);
         chk($sformatf("%s ab k=%0d", tag, k), {6'd0, gate_a, gate_b},
             (k < RUN) ? 8'(k / VEC) : 8'd0);
         chk($sformatf("%s busy k=%0d", tag, k), {7'd0, busy}, (k < RUN) ? 8'd1 : 8'd0);
         chk($sformatf("%s done k=%0d", tag, k), {7'd0, done}, (k == RUN) ? 8'd1 : 8'd0);
         chk($sformatf("%s err k=%0d", tag, k), {5'd0, err_cnt}, 8'(ne));
         chk($sformatf("%s fv k=%0d", tag, k), {7'd0, fail_valid}, (fm >= 0) ? 8'd1 : 8'd0);
         chk($sformatf("%s ff k=%0d", tag, k), {6'd0, first_fail}, (fm >= 0) ? 8'(fm) : 8'd0);
         chk($sformatf("%s pass k=%0d", tag, k), {7'd0, pass},
             (k >= RUN && ne == 0) ? 8'd1 : 8'd0);
         if (disturb == 1) begin
            if (k == 3) start = 1'b1;
            if (k == 4) start = 1'b0;
            if (k == 7) truth = 4'b0000;
         end
         if (k < RUN + 1) @(negedge clk);
      end
   endtask

   task automatic pulse_start(input logic [3:0] tt, input logic [3:0] fn);
      truth   = tt;
      gate_fn = fn;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int seen_done;
      logic [3:0] rt, rf;
      rst     = 1'b1;
      start   = 1'b0;
      truth   = 4'b0000;
      gate_fn = 4'b1000;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);

      // AND gate, AND table
      pulse_start(4'b1000, 4'b1000);
      run_check("and_ok", 4'b1000, 4'b1000, 0);

      // AND gate, XOR table
      pulse_start(4'b0110, 4'b1000);
      run_check("and_xor", 4'b0110, 4'b1000, 0);

      // output stuck at 1, then stuck at 0
      pulse_start(4'b1000, 4'b1111);
      run_check("stuck1", 4'b1000, 4'b1111, 0);
      pulse_start(4'b1000, 4'b0000);
      run_check("stuck0", 4'b1000, 4'b0000, 0);

      // reset during APPLY of vector 2'b10
      pulse_start(4'b1000, 4'b1000);
      repeat (2 * VEC + 1) @(negedge clk);
      chk("rst_mid ab", {6'd0, gate_a, gate_b}, 8'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_vals("rst_mid");
      seen_done = 0;
      for (int i = 0; i < RUN + 4; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen_done++;
      end
      chk("rst_mid no_done", 8'(seen_done), 8'd0);
      pulse_start(4'b1000, 4'b1000);
      run_check("after_rst", 4'b1000, 4'b1000, 0);

      // start re-pulsed and truth changed while busy
      pulse_start(4'b1000, 4'b1000);
      run_check("disturb", 4'b1000, 4'b1000, 1);

      // start held high: back-to-back runs, first passes, second fails
      truth   = 4'b1000;
      gate_fn = 4'b1000;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      run_check("held1", 4'b1000, 4'b1000, 0);
      gate_fn = 4'b0001;
      @(negedge clk);
      run_check("held2", 4'b1000, 4'b0001, 0);
      start = 1'b0;
      @(negedge clk);

      // randomized gate behaviour and expected tables
      for (int r = 0; r < 8; r++) begin
         rt = 4'($urandom_range(0, 15));
         rf = 4'($urandom_range(0, 15));
         pulse_start(rt, rf);
         run_check($sformatf("rand%0d", r), rt, rf, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/gate_tt_sequencer.md
Name: gate_tt_sequencer

Overview:
Self-test controller for a 2-input single-bit gate (and_gate and its siblings in the gate library). On a start request it drives the gate's a/b inputs through all four truth-table vectors, holds each one for a programmable settle time, and samples the gate output. It then compares each sample against a latched 4-bit expected truth table and reports pass/fail, the error count and the first failing vector. It is the synthesizable counterpart of the per-gate testbenches and sits between a host/top-level and one gate instance.

Parameters:
HOLD_CYCLES, 4, cycles each vector is driven before sampling; legal range 1..2^CNT_W-1.
CNT_W, 8, width of the internal hold counter.

Ports:
clk  input  1  single system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  run request; accepted only in IDLE.
truth  input  4  expected output per vector: truth[{a,b}]. AND = 4'b1000, OR = 4'b1110, XOR = 4'b0110.
gate_a  output  1  drives gate input a.
gate_b  output  1  drives gate input b.
gate_y  input  1  gate output under test.
busy  output  1  high in APPLY and CHECK.
done  output  1  one-cycle pulse in FINISH.
pass  output  1  1 when the last run had zero mismatches; held until next accepted start.
err_cnt  output  3  mismatch count of the last run, 0..4.
fail_valid  output  1  at least one mismatch recorded in the current/last run.
first_fail  output  2  vector index {a,b} of the first mismatch; valid when fail_valid=1.

Behaviour:
- All outputs registered. Reset values: state IDLE, gate_a=gate_b=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, first_fail=0, idx=0, hold counter=0.
- Reset mid-run: at the next edge everything returns to reset values; the partial run is discarded and no done is issued.
- IDLE: gate_a/gate_b=0. On start=1, latch truth into truth_q, set idx=0, clear err_cnt, fail_valid, first_fail and pass, then go to APPLY. Changes to truth after acceptance have no effect.
- APPLY: {gate_a,gate_b}=idx. Hold counter counts 0..HOLD_CYCLES-1. On the final count, clear the counter and go to CHECK.
- CHECK (1 cycle): inputs keep the same vector. Sample gate_y and compare with truth_q[idx]. On mismatch, increment err_cnt; if fail_valid=0, set first_fail=idx and fail_valid=1. If idx=3, go to FINISH; otherwise increment idx and go to APPLY.
- FINISH (1 cycle): done=1, busy=0, pass=(err_cnt==0), where err_cnt already includes the idx-3 result. gate_a/gate_b return to 0. Next state is IDLE.
- Timing: if start is sampled at edge E0, APPLY begins at E0. Each vector takes HOLD_CYCLES+1 cycles, so done is high in the cycle starting at E0+4*(HOLD_CYCLES+1). With defaults, done is high 20 cycles after the start edge.
- start while busy or in FINISH is ignored. If start is held high continuously, a new run is accepted from IDLE, giving a period of 4*(HOLD_CYCLES+1)+2 cycles.
- err_cnt cannot exceed 4; no wrap.
- A gate_y value of X/Z compares as a mismatch in simulation (compare with !==).

Test Plan:
1. AND gate instance, truth=4'b1000, HOLD_CYCLES=4, 1-cycle start pulse -> vectors 00,01,10,11 each held 5 cycles; done pulse 20 cycles after start edge; pass=1, err_cnt=0, fail_valid=0.
2. AND gate instance, truth=4'b0110 -> mismatches at idx 1,2,3; err_cnt=3, first_fail=2'b01, fail_valid=1, pass=0.
3. gate_y tied to 1, truth=4'b1000 -> err_cnt=3, first_fail=2'b00, pass=0; gate_y tied to 0 -> err_cnt=1, first_fail=2'b11.
4. rst asserted for 1 cycle during the APPLY of vector 2'b10 -> next cycle all outputs at reset values with no done pulse; a subsequent start completes a full run with pass=1.
5. start re-pulsed during busy, and truth changed to 4'b0000 mid-run -> both ignored; results match scenario 1.
6. start held high continuously -> back-to-back runs with done pulses 22 cycles apart; pass/err_cnt are cleared at each accept.
